morse_tx: RTL and testbench

- Parametrised Morse character transmitter covering the full A–Z alphabet.
- Operation: on a start request, latches a letter index, looks up a variable-length on/off pattern, and shifts it onto a single serial output at one bit per time unit. Each character is followed by a fixed inter-character gap.
- Successor to the fixed 8-letter, fixed-14-bit lab shifter. Adds a start/busy/done handshake, abort, invalid-index detection and a configurable time unit.
- Drives one LED/buzzer output from the board top level.

---
 rtl/morse_pkg.sv | 93 +++++++++
 rtl/morse_tick.sv | 38 +++
 rtl/morse_tx.sv | 176 +++++++++++++++++
 tb/tb_morse_tx.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// -----------------------------------------------------------------------------
// morse_pkg
// Shared types and constants for the Morse transmitter.
//   PAT_W        width of the left-aligned on/off pattern
//   LEN_W        width of the pattern length field (1..13)
//   NUM_LETTERS  number of encodable letters (A..Z)
//   state_e      transmitter FSM states
//   morse_lookup letter index -> {pattern, length}
// Encoding: dot = 1, dash = 111, gap between symbols = 0, MSB first.
// -----------------------------------------------------------------------------
package morse_pkg;

    localparam int unsigned PAT_W       = 16;
    localparam int unsigned LEN_W       = 4;
    localparam int unsigned NUM_LETTERS = 26;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } state_e;

    typedef struct packed {
        logic [PAT_W-1:0] pat;
        logic [LEN_W-1:0] len;
    } morse_char_t;

    // Each letter is stored as a symbol count and up to four dash flags,
    // first symbol in bit 3 (1 = dash). The keyed pattern is then expanded
    // from those symbols, so the table stays short and readable.
    function automatic morse_char_t morse_lookup(input int unsigned idx);
        int unsigned      n;
        logic [3:0]       sym;
        logic [PAT_W-1:0] acc;
        int unsigned      pos;
        morse_char_t      r;

        case (idx)
            0:       begin n = 2; sym = 4'b0100; end // A .-
            1:       begin n = 4; sym = 4'b1000; end // B -...
            2:       begin n = 4; sym = 4'b1010; end // C -.-.
            3:       begin n = 3; sym = 4'b1000; end // D -..
            4:       begin n = 1; sym = 4'b0000; end // E .
            5:       begin n = 4; sym = 4'b0010; end // F ..-.
            6:       begin n = 3; sym = 4'b1100; end // G --.
            7:       begin n = 4; sym = 4'b0000; end // H ....
            8:       begin n = 2; sym = 4'b0000; end // I ..
            9:       begin n = 4; sym = 4'b0111; end // J .---
            10:      begin n = 3; sym = 4'b1010; end // K -.-
            11:      begin n = 4; sym = 4'b0100; end // L .-..
            12:      begin n = 2; sym = 4'b1100; end // M --
            13:      begin n = 2; sym = 4'b1000; end // N -.
            14:      begin n = 3; sym = 4'b1110; end // O ---
            15:      begin n = 4; sym = 4'b0110; end // P .--.
            16:      begin n = 4; sym = 4'b1101; end // Q --.-
            17:      begin n = 3; sym = 4'b0100; end // R .-.
            18:      begin n = 3; sym = 4'b0000; end // S ...
            19:      begin n = 1; sym = 4'b1000; end // T -
            20:      begin n = 3; sym = 4'b0010; end // U ..-
            21:      begin n = 4; sym = 4'b0001; end // V ...-
            22:      begin n = 3; sym = 4'b0110; end // W .--
            23:      begin n = 4; sym = 4'b1001; end // X -..-
            24:      begin n = 4; sym = 4'b1011; end // Y -.--
            25:      begin n = 4; sym = 4'b1100; end // Z --..
            default: begin n = 0; sym = 4'b0000; end
        endcase

        acc = '0;
        pos = 0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (i < n) begin
                if (i != 0) begin
                    acc = acc << 1;
                    pos = pos + 1;
                end
                if (sym[3]) begin
                    acc = (acc << 3) | PAT_W'(3'b111);
                    pos = pos + 3;
                end else begin
                    acc = (acc << 1) | PAT_W'(1'b1);
                    pos = pos + 1;
                end
                sym = sym << 1;
            end
        end

        // Built right-aligned, then moved to the MSB end for shifting out.
        r.pat = acc << (PAT_W - pos);
        r.len = LEN_W'(pos);
        return r;
    endfunction

endpackage

// File: rtl/morse_tick.sv
// -----------------------------------------------------------------------------
// morse_tick
// Down-counting time-unit divider. Counts DIV-1 .. 0 and reloads, so tick
// is high for one clk out of every DIV. With DIV = 1 the count stays at 0
// and tick is permanently high.
// Ports:
//   clk      in   system clock
//   Reset_b  in   asynchronous active-low reset (count -> 0)
//   clr      in   synchronous reload of the count to DIV-1
//   tick     out  high while the count is 0
// -----------------------------------------------------------------------------
module morse_tick #(
    parameter int unsigned DIV = 25_000_000
) (
    input  logic clk,
    input  logic Reset_b,
    input  logic clr,
    output logic tick
);

    localparam int unsigned    CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge Reset_b) begin
        if (!Reset_b) begin
            cnt_q <= '0;
        end else if (clr || (cnt_q == '0)) begin
            cnt_q <= LAST;
        end else begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign tick = (cnt_q == '0);

endmodule

// File: rtl/morse_tx.sv
// -----------------------------------------------------------------------------
// morse_tx
// Morse character transmitter for A..Z. A start in IDLE latches the letter's
// pattern and shifts it out MSB first, one bit per DIV clocks, followed by
// GAP_UNITS zero units. All outputs are registered.
// Parameters: DIV (clk per time unit, >= 1), GAP_UNITS (>= 0), SEL_W.
// Ports:
//   clk       in   system clock
//   Reset_b   in   asynchronous active-low reset
//   start     in   transmit request, sampled only in IDLE
//   sel       in   letter index, 0 = A .. 25 = Z
//   abort     in   synchronous cancel of the character in flight
//   repeat_i  in   (MORSE_TX_REPEAT_EN only) restart the latched letter
//   busy      out  high while sending a character or its gap
//   done      out  one-cycle pulse on normal completion
//   err       out  one-cycle pulse for start with sel > 25
//   tx_out    out  serial output, 1 = key down
// Build option: define MORSE_TX_REPEAT_EN to add the repeat_i input.
// -----------------------------------------------------------------------------
module morse_tx
    import morse_pkg::*;
#(
    parameter int unsigned DIV       = 25_000_000,
    parameter int unsigned GAP_UNITS = 3,
    parameter int unsigned SEL_W     = 5
) (
    input  logic             clk,
    input  logic             Reset_b,
    input  logic             start,
    input  logic [SEL_W-1:0] sel,
    input  logic             abort,
`ifdef MORSE_TX_REPEAT_EN
    input  logic             repeat_i,
`endif
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             tx_out
);

    localparam int unsigned   GW       = (GAP_UNITS > 1) ? $clog2(GAP_UNITS) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_UNITS > 0) ? GAP_UNITS - 1 : 0);

    state_e           state_q;
    logic [PAT_W-1:0] shift_q;
    logic [LEN_W-1:0] bits_left_q;
    logic [GW-1:0]    gap_cnt_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;
    logic             tx_q;
`ifdef MORSE_TX_REPEAT_EN
    logic [PAT_W-1:0] hold_pat_q;
    logic [LEN_W-1:0] hold_len_q;
`endif

    logic        tick;
    logic        tick_clr;
    logic        sel_ok;
    morse_char_t sel_char;
    logic        last_bit;
    logic        gap_done;
    logic        char_end;

    assign sel_ok   = (32'(sel) < NUM_LETTERS);
    assign sel_char = morse_lookup(32'(sel));
    assign tick_clr = (state_q == IDLE) && start && sel_ok;

    // Character boundary: end of the last bit when there is no gap,
    // otherwise end of the last gap unit.
    assign last_bit = (state_q == SEND) && tick && (bits_left_q == LEN_W'(1));
    assign gap_done = (state_q == GAP) && tick && (gap_cnt_q == '0);
    assign char_end = (GAP_UNITS == 0) ? last_bit : gap_done;

    morse_tick #(
        .DIV(DIV)
    ) u_tick (
        .clk     (clk),
        .Reset_b (Reset_b),
        .clr     (tick_clr),
        .tick    (tick)
    );

    always_ff @(posedge clk or negedge Reset_b) begin
        if (!Reset_b) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            bits_left_q <= '0;
            gap_cnt_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            tx_q        <= 1'b0;
`ifdef MORSE_TX_REPEAT_EN
            hold_pat_q  <= '0;
            hold_len_q  <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;

            if (abort && (state_q != IDLE)) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                tx_q    <= 1'b0;
            end else if (char_end) begin
                done_q <= 1'b1;
`ifdef MORSE_TX_REPEAT_EN
                // Tick counter has just reloaded, so the first repeated bit
                // gets a full unit without any clear.
                if (repeat_i) begin
                    state_q     <= SEND;
                    shift_q     <= hold_pat_q;
                    bits_left_q <= hold_len_q;
                    tx_q        <= hold_pat_q[PAT_W-1];
                end else
`endif
                begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    tx_q    <= 1'b0;
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            if (sel_ok) begin
                                state_q     <= SEND;
                                shift_q     <= sel_char.pat;
                                bits_left_q <= sel_char.len;
                                tx_q        <= sel_char.pat[PAT_W-1];
                                busy_q      <= 1'b1;
`ifdef MORSE_TX_REPEAT_EN
                                hold_pat_q  <= sel_char.pat;
                                hold_len_q  <= sel_char.len;
`endif
                            end else begin
                                err_q <= 1'b1;
                            end
                        end
                    end
                    SEND: begin
                        if (tick) begin
                            // Last bit without a gap is taken by char_end.
                            if (bits_left_q == LEN_W'(1)) begin
                                state_q   <= GAP;
                                gap_cnt_q <= GAP_LAST;
                                tx_q      <= 1'b0;
                            end else begin
                                shift_q     <= shift_q << 1;
                                bits_left_q <= bits_left_q - LEN_W'(1);
                                tx_q        <= shift_q[PAT_W-2];
                            end
                        end
                    end
                    GAP: begin
                        if (tick) begin
                            gap_cnt_q <= gap_cnt_q - GW'(1);
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        tx_q    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;
    assign tx_out = tx_q;

endmodule

// File: tb/tb_morse_tx.sv
// -----------------------------------------------------------------------------
// tb_morse_tx
// Self-checking bench for morse_tx with DIV = 4, GAP_UNITS = 3. The reference
// model expands each letter from its dot/dash text into a per-cycle queue of
// expected tx_out values; busy is "queue not empty" and done fires when the
// queue drains.
// -----------------------------------------------------------------------------
module tb_morse_tx;

    localparam int unsigned DIV  = 4;
    localparam int unsigned GAPU = 3;

    logic       clk;
    logic       Reset_b;
    logic       start_r;
    logic [4:0] sel_r;
    logic       abort_r;
    logic       rep_r;
    logic       busy;
    logic       done;
    logic       err;
    logic       tx_out;

    int n_vec = 0;
    int n_err = 0;

    string codes [26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....",
                          "..", ".---", "-.-", ".-..", "--", "-.", "---", ".--.",
                          "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-",
                          "-.--", "--.."};

    bit m_wave [$];
    bit m_done;
    bit m_err;
    int m_cur;

    morse_tx #(
        .DIV       (DIV),
        .GAP_UNITS (GAPU),
        .SEL_W     (5)
    ) dut (
        .clk      (clk),
        .Reset_b  (Reset_b),
        .start    (start_r),
        .sel      (sel_r),
        .abort    (abort_r),
`ifdef MORSE_TX_REPEAT_EN
        .repeat_i (rep_r),
`endif
        .busy     (busy),
        .done     (done),
        .err      (err),
        .tx_out   (tx_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void add_unit(input bit b);
        for (int k = 0; k < int'(DIV); k++) m_wave.push_back(b);
    endfunction

    function automatic void push_wave(input int idx);
        string s;
        s = codes[idx];
        for (int i = 0; i < s.len(); i++) begin
            if (i > 0) add_unit(1'b0);
            if (s.getc(i) == ".") begin
                add_unit(1'b1);
            end else begin
                add_unit(1'b1); add_unit(1'b1); add_unit(1'b1);
            end
        end
        for (int g = 0; g < int'(GAPU); g++) add_unit(1'b0);
    endfunction

    function automatic void model_edge();
        m_done = 1'b0;
        m_err  = 1'b0;
        if (!Reset_b) begin
            m_wave.delete();
        end else if (m_wave.size() != 0) begin
            if (abort_r) begin
                m_wave.delete();
            end else begin
                void'(m_wave.pop_front());
                if (m_wave.size() == 0) begin
                    m_done = 1'b1;
                    if (rep_r) push_wave(m_cur);
                end
            end
        end else if (start_r) begin
            if (int'(sel_r) <= 25) begin
                m_cur = int'(sel_r);
                push_wave(m_cur);
            end else begin
                m_err = 1'b1;
            end
        end
    endfunction

    task automatic compare(input string pfx);
        bit eb, et;
        eb = (m_wave.size() != 0);
        et = eb ? m_wave[0] : 1'b0;
        chk({pfx, "_busy"}, busy, eb);
        chk({pfx, "_tx"}, tx_out, et);
        chk({pfx, "_done"}, done, m_done);
        chk({pfx, "_err"}, err, m_err);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare("cyc");
    endtask

    // Reset pulse placed between clock edges; outputs must clear at once.
    task automatic async_reset_pulse();
        #2;
        Reset_b = 1'b0;
        m_wave.delete();
        m_done = 1'b0;
        m_err  = 1'b0;
        #1;
        compare("arst");
        #1;
        Reset_b = 1'b1;
    endtask

    task automatic send_char(input int s, input int exp_busy, input int poke, input string tag);
        int cnt, cyc;
        bit got;
        cnt = 0; cyc = 1; got = 1'b0;
        start_r = 1'b1; sel_r = 5'(s);
        step();
        start_r = 1'b0;
        if (busy) cnt++;
        for (int i = 0; i < 200 && !got; i++) begin
            if (cyc == poke) begin
                start_r = 1'b1; sel_r = 5'd0;
            end else begin
                start_r = 1'b0; sel_r = 5'($urandom_range(0, 31));
            end
            step();
            cyc++;
            if (done) begin
                got = 1'b1;
                chk({tag, "_done_cycle"}, cyc, exp_busy + 1);
            end else if (busy) begin
                cnt++;
            end
        end
        start_r = 1'b0;
        chk({tag, "_done_seen"}, got, 1);
        chk({tag, "_busy_cycles"}, cnt, exp_busy);
    endtask

    initial begin
        int dcnt, lowcnt;
        bit stopped;
        Reset_b = 1'b0; start_r = 1'b0; sel_r = '0; abort_r = 1'b0; rep_r = 1'b0;
        m_done = 1'b0; m_err = 1'b0; m_cur = 0;
        #3;
        compare("reset");
        step();
        step();
        #2;
        Reset_b = 1'b1;

        // E, A, invalid index, J with an ignored start in flight
        send_char(4, 16, -1, "E");
        send_char(0, 32, -1, "A");

        start_r = 1'b1; sel_r = 5'd26;
        step();
        chk("inv_err_pulse", err, 1);
        chk("inv_busy", busy, 0);
        start_r = 1'b0;
        step();
        chk("inv_err_once", err, 0);
        chk("inv_no_done", done, 0);

        send_char(9, 64, 10, "J");

        // Abort part-way through J
        start_r = 1'b1; sel_r = 5'd9;
        step();
        start_r = 1'b0;
        for (int i = 1; i < 20; i++) step();
        abort_r = 1'b1;
        step();
        abort_r = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_tx", tx_out, 0);
        dcnt = 0;
        for (int i = 0; i < 70; i++) begin
            step();
            if (done) dcnt++;
        end
        chk("abort_no_done", dcnt, 0);

        // Asynchronous reset mid-J, then T
        start_r = 1'b1; sel_r = 5'd9;
        step();
        start_r = 1'b0;
        for (int i = 0; i < 15; i++) step();
        async_reset_pulse();
        chk("arst_tx_now", tx_out, 0);
        send_char(19, 24, -1, "T");

`ifdef MORSE_TX_REPEAT_EN
        rep_r = 1'b1;
        start_r = 1'b1; sel_r = 5'd4;
        step();
        start_r = 1'b0;
        dcnt = 0; lowcnt = 0;
        for (int i = 0; i < 64; i++) begin
            step();
            if (done) dcnt++;
            if (!busy) lowcnt++;
        end
        chk("rep_done_count", dcnt, 4);
        chk("rep_busy_low", lowcnt, 0);
        rep_r = 1'b0;
        stopped = 1'b0;
        for (int i = 0; i < 40 && !stopped; i++) begin
            step();
            if (!busy) stopped = 1'b1;
        end
        chk("rep_stops", stopped, 1);
`endif

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            start_r = ($urandom_range(0, 3) == 0);
            sel_r   = 5'($urandom_range(0, 31));
            abort_r = ($urandom_range(0, 39) == 0);
`ifdef MORSE_TX_REPEAT_EN
            rep_r   = ($urandom_range(0, 1) == 0);
`endif
            step();
            if ($urandom_range(0, 599) == 0) async_reset_pulse();
        end
        start_r = 1'b0; abort_r = 1'b0; rep_r = 1'b0;
        stopped = 1'b0;
        for (int i = 0; i < 200 && !stopped; i++) begin
            step();
            if (!busy) stopped = 1'b1;
        end
        chk("final_idle", stopped, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
